// File: rtl/hslp_mon_pkg.sv
// Shared definitions for the HSLP approximate-multiplier error monitor:
// FSM state encoding, default widths and the accumulator width rule.
package hslp_mon_pkg;

    localparam int unsigned W_DEF      = 8;
    localparam int unsigned LOG2_N_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // ED sum holds N samples of a 2W-bit distance without overflow
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2_n);
        return 2 * w + log2_n;
    endfunction

endpackage

// File: rtl/hslp_ed_calc.sv
// Two-stage datapath: S1 registers the exact product and the approximate
// product, S2 registers |exact - apx| plus the nonzero / over-estimate flags.
module hslp_ed_calc
    import hslp_mon_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [2*W-1:0]   prod_apx_i,
    output logic             s1_valid_o,
    output logic             s2_valid_o,
    output logic [2*W-1:0]   ed_o,
    output logic             nz_o,
    output logic             over_o
);

    localparam int unsigned PW = 2 * W;

    logic          s1_valid_q, s2_valid_q;
    logic [PW-1:0] exact_q, apx_q;
    logic [PW-1:0] ed_q, ed_d;
    logic          nz_q, over_q;

    always_comb begin
        ed_d = '0;
        if (exact_q >= apx_q) ed_d = exact_q - apx_q;
        else                  ed_d = apx_q - exact_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            exact_q    <= '0;
            apx_q      <= '0;
            ed_q       <= '0;
            nz_q       <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            s1_valid_q <= fire_i;
            s2_valid_q <= s1_valid_q;
            if (fire_i) begin
                exact_q <= PW'(a_i) * PW'(b_i);
                apx_q   <= prod_apx_i;
            end
            if (s1_valid_q) begin
                ed_q   <= ed_d;
                nz_q   <= (exact_q != apx_q);
                over_q <= (apx_q > exact_q);
            end
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign s2_valid_o = s2_valid_q;
    assign ed_o       = ed_q;
    assign nz_o       = nz_q;
    assign over_o     = over_q;

endmodule

// File: rtl/hslp_err_monitor.sv
// Error-statistics monitor for approximate multipliers: windowed ED sum,
// max ED, erroneous-sample and over-estimate counts over 2**LOG2_N samples.
module hslp_err_monitor
    import hslp_mon_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned LOG2_N = LOG2_N_DEF,
    parameter int unsigned ACC_W  = acc_width(W, LOG2_N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic [2*W-1:0]      prod_apx,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [2*W-1:0]      max_ed,
    output logic [LOG2_N:0]     err_cnt,
    output logic [LOG2_N:0]     over_cnt
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = LOG2_N + 1;
    localparam logic [CW-1:0] N_SAMPLES = CW'(1) << LOG2_N;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [PW-1:0]     max_q, max_d;
    logic [CW-1:0]     err_q, err_d;
    logic [CW-1:0]     over_q, over_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fire;
    logic              s1_valid, s2_valid, ed_nz, ed_over;
    logic [PW-1:0]     ed;

    assign fire = in_valid & in_ready_q;

    hslp_ed_calc #(.W(W)) u_ed_calc (
        .clk        (clk),
        .rst        (rst),
        .fire_i     (fire),
        .a_i        (a),
        .b_i        (b),
        .prod_apx_i (prod_apx),
        .s1_valid_o (s1_valid),
        .s2_valid_o (s2_valid),
        .ed_o       (ed),
        .nz_o       (ed_nz),
        .over_o     (ed_over)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        max_d   = max_q;
        err_d   = err_q;
        over_d  = over_q;

        if (s2_valid) begin
            sum_d  = sum_q + ACC_W'(ed);
            err_d  = err_q + CW'(ed_nz);
            over_d = over_q + CW'(ed_over);
            if (ed > max_q) max_d = ed;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // pipe is empty here, so clearing cannot race with accumulation
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    err_d   = '0;
                    over_d  = '0;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == N_SAMPLES) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid && !s2_valid) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_q == ST_DRAIN) && (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            err_q      <= '0;
            over_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            err_q      <= err_d;
            over_q     <= over_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_ed   = sum_q;
    assign max_ed   = max_q;
    assign err_cnt  = err_q;
    assign over_cnt = over_q;

endmodule
